// File: rtl/seq_pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx_pkg
// Brief    : Shared state encoding, default pattern and counter width for
//            the serial pattern transmitter.
// Revision : 1.0
// ============================================================================
package seq_pattern_tx_pkg;

  localparam int         c_PAT_LEN_DEFAULT = 4;
  localparam logic [3:0] c_PATTERN_DEFAULT = 4'b1010;
  localparam int         c_CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A requested repetition count of zero still sends the pattern once.
  function automatic logic [c_CNT_W-1:0] norm_repeat(input logic [c_CNT_W-1:0] rep);
    return (rep == '0) ? c_CNT_W'(1) : rep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx_if
// Brief    : Control and serial-output bundle of the pattern transmitter.
// Revision : 1.0
// ============================================================================
interface seq_pattern_tx_if;
  import seq_pattern_tx_pkg::*;

  logic               i_start;
  logic [c_CNT_W-1:0] i_repeat;
  logic [c_CNT_W-1:0] i_gap;
  logic               i_abort;
  logic               o_x;
  logic               o_valid;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_repeat, i_gap, i_abort,
    input  o_x, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_repeat, i_gap, i_abort,
    output o_x, o_valid, o_busy, o_done
  );

endinterface
`default_nettype wire

// File: rtl/seq_pattern_tx_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_cnt
// Brief    : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0
// ============================================================================
module seq_tx_cnt #(
  parameter int WIDTH = 4
) (
  input  wire logic             i_clk,
  input  wire logic             i_reset,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic      [WIDTH-1:0] o_count,
  output logic                  o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Brief    : Moore FSM sending a fixed bit pattern MSB first, repeated with
//            optional idle gaps; abortable, with a completion pulse.
// Revision : 1.0
// ============================================================================
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int               PAT_LEN = c_PAT_LEN_DEFAULT,
  parameter logic [PAT_LEN-1:0] PATTERN = c_PATTERN_DEFAULT
) (
  input wire logic      i_clk,
  input wire logic      i_reset,
  seq_pattern_tx_if.slave bus
);

  localparam int               IDX_W      = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(PAT_LEN - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [c_CNT_W-1:0] r_gap_cfg;

  logic               w_cfg_load;
  logic               w_idx_load;
  logic               w_idx_dec;
  logic               w_rep_load;
  logic               w_rep_dec;
  logic               w_gap_load;
  logic               w_gap_dec;

  logic [IDX_W-1:0]   w_idx_cnt;
  logic               w_idx_zero;
  logic [c_CNT_W-1:0] w_rep_cnt;
  logic               w_rep_zero;
  logic [c_CNT_W-1:0] w_gap_cnt_unused;
  logic               w_gap_zero;
  logic               w_more_reps;

  seq_tx_cnt #(.WIDTH(IDX_W)) u_idx_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_idx_load),
    .i_load_val (c_IDX_LAST),
    .i_dec      (w_idx_dec),
    .o_count    (w_idx_cnt),
    .o_zero     (w_idx_zero)
  );

  seq_tx_cnt #(.WIDTH(c_CNT_W)) u_rep_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_rep_load),
    .i_load_val (norm_repeat(bus.i_repeat)),
    .i_dec      (w_rep_dec),
    .o_count    (w_rep_cnt),
    .o_zero     (w_rep_zero)
  );

  // Loaded with gap-1 so the zero flag marks the final idle cycle.
  seq_tx_cnt #(.WIDTH(c_CNT_W)) u_gap_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_gap_load),
    .i_load_val (r_gap_cfg - c_CNT_W'(1)),
    .i_dec      (w_gap_dec),
    .o_count    (w_gap_cnt_unused),
    .o_zero     (w_gap_zero)
  );

  // The repetition count still includes the one just finishing.
  assign w_more_reps = !w_rep_zero && (w_rep_cnt != c_CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_gap_cfg <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_cfg_load) begin
        r_gap_cfg <= bus.i_gap;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cfg_load   = 1'b0;
    w_idx_load   = 1'b0;
    w_idx_dec    = 1'b0;
    w_rep_load   = 1'b0;
    w_rep_dec    = 1'b0;
    w_gap_load   = 1'b0;
    w_gap_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          w_next_state = ST_SEND;
          w_cfg_load   = 1'b1;
          w_idx_load   = 1'b1;
          w_rep_load   = 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.i_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_idx_zero) begin
          w_rep_dec = 1'b1;
          if (!w_more_reps) begin
            w_next_state = ST_DONE;
          end else if (r_gap_cfg != '0) begin
            w_next_state = ST_GAP;
            w_gap_load   = 1'b1;
          end else begin
            w_idx_load = 1'b1;
          end
        end else begin
          w_idx_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.i_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_gap_zero) begin
          w_next_state = ST_SEND;
          w_idx_load   = 1'b1;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign bus.o_valid = (r_state == ST_SEND);
  assign bus.o_x     = (r_state == ST_SEND) && PATTERN[w_idx_cnt];
  assign bus.o_busy  = (r_state != ST_IDLE);
  assign bus.o_done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Brief    : Directed vector bench for seq_pattern_tx (default 4-bit 1010).
// Revision : 1.0
// ============================================================================
module tb_seq_pattern_tx;

  typedef struct {
    logic [3:0]  reps;
    logic [3:0]  gap;
    int          len;
    logic [63:0] ev;
    logic [63:0] ex;
    bit          perturb;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;
  vec_t vecs[9];

  seq_pattern_tx_if bus();

  seq_pattern_tx u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] obs();
    return {bus.o_busy, bus.o_done, bus.o_valid, bus.o_x};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy/done/valid/x=%b required %b", name, act, exp);
    end
  endtask

  task automatic run_burst(input int id, input vec_t v);
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_repeat = v.reps;
    bus.i_gap    = v.gap;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int k = 0; k < v.len; k++) begin
      check($sformatf("vec%0d_cyc%0d", id, k), obs(), {2'b10, v.ev[v.len-1-k], v.ex[v.len-1-k]});
      if (v.perturb && k == 1) begin
        bus.i_start  = 1'b1;
        bus.i_repeat = 4'd5;
        bus.i_gap    = 4'd7;
      end
      if (v.perturb && k == 2) bus.i_start = 1'b0;
      @(negedge clk);
    end
    check($sformatf("vec%0d_done", id), obs(), 4'b1100);
    if (v.perturb) bus.i_start = 1'b1;
    @(negedge clk);
    check($sformatf("vec%0d_idle", id), obs(), 4'b0000);
    bus.i_start = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_idle2", id), obs(), 4'b0000);
  endtask

  initial begin
    logic [3:0] pat;
    pat    = 4'b1010;
    n_vec  = 0;
    n_fail = 0;

    vecs[0] = '{4'd1,  4'd0, 4,  64'b1111,         64'b1010,         1'b0};
    vecs[1] = '{4'd2,  4'd2, 10, 64'b1111001111,   64'b1010001010,   1'b0};
    vecs[2] = '{4'd0,  4'd0, 4,  64'b1111,         64'b1010,         1'b0};
    vecs[3] = '{4'd3,  4'd0, 12, 64'b111111111111, 64'b101010101010, 1'b0};
    vecs[4] = '{4'd1,  4'd9, 4,  64'b1111,         64'b1010,         1'b0};
    vecs[5] = '{4'd2,  4'd1, 9,  64'b111101111,    64'b101001010,    1'b0};
    vecs[6] = '{4'd2,  4'd2, 10, 64'b1111001111,   64'b1010001010,   1'b1};
    vecs[7] = '{4'd0,  4'd5, 4,  64'b1111,         64'b1010,         1'b0};
    vecs[8] = '{4'd15, 4'd0, 60, {4'h0, {60{1'b1}}}, {4'h0, {15{4'b1010}}}, 1'b0};

    bus.i_start  = 1'b0;
    bus.i_repeat = 4'd0;
    bus.i_gap    = 4'd0;
    bus.i_abort  = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", obs(), 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_burst(i, vecs[i]);

    // Start together with abort in IDLE must not launch a burst.
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_abort  = 1'b1;
    bus.i_repeat = 4'd1;
    @(negedge clk);
    check("start_abort_idle", obs(), 4'b0000);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle2", obs(), 4'b0000);

    // Abort on the third bit of a two-repetition burst.
    bus.i_start  = 1'b1;
    bus.i_repeat = 4'd2;
    bus.i_gap    = 4'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort_bit%0d", k), obs(), {3'b101, pat[3-k]});
      if (k == 2) bus.i_abort = 1'b1;
      @(negedge clk);
    end
    check("abort_next", obs(), 4'b0000);
    bus.i_abort = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", k), obs(), 4'b0000);
    end
    run_burst(100, vecs[0]);

    // Reset while in the inter-repetition gap.
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_repeat = 4'd2;
    bus.i_gap    = 4'd3;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rstgap_bit%0d", k), obs(), {3'b101, pat[3-k]});
      @(negedge clk);
    end
    check("rstgap_gap", obs(), 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    check("rstgap_next", obs(), 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rstgap_quiet%0d", k), obs(), 4'b0000);
    end
    run_burst(101, vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
